ex_stage_unit: RTL and testbench
================================

Name: ex_stage_unit

Overview:
- Execute stage of the 16-bit pipelined processor. Sits between the 91-bit ID/EX buffer and the memory stage.
- Selects operands from the ID/EX fields, the forwarding unit or the immediate, then runs the ALU, I/O, stack, address and branch logic.
- Registers the 76-bit EX/MEM payload on the clock.
- Branch decision outputs are combinational so fetch can redirect in the same cycle.

Parameters:
- None.

Ports:
- clk  in  1  stage clock; registers update on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- IOR, IOW, OPS, ALU, MR, MW, WB, JMP, SP, SPOP, JWSP, IMM, Stack_PC, Stack_Flags  in  1 each  ID/EX control bits.
- FD  in  2  flag destination select.
- FGS  in  2  branch condition select.
- ALU_OP  in  3  ALU operation.
- WB_Address, SRC_Address  in  3 each  register addresses.
- Data1, Data2  in  16 each  register operands A and B.
- Immediate_Value  in  16  immediate word.
- PC  in  32  instruction PC.
- Forwarding_Unit_Selectors  in  2  bit0 forwards A, bit1 forwards B.
- Data_From_Forwarding_Unit1, Data_From_Forwarding_Unit2  in  16 each  forwarded A and B.
- Flags, Flags_From_Memory  in  3 each  flags {NF,CF,ZF}.
- INPUT_PORT  in  16  input port value.
- Stack_Pointer  in  32  current SP.
- MR_Out, MW_Out, WB_Out, JWSP_Out, Stack_PC_Out, Stack_Flags_Out  out  1 each  registered copies of the control bits.
- WB_Address_Out  out  3  registered.
- Data  out  32  registered result.
- Address  out  32  registered memory address.
- Final_Flags  out  3  registered flags {NF,CF,ZF}.
- Stack_Pointer_Out  out  32  combinational next SP.
- Taken_Jump  out  1  combinational.
- To_PC_Selector  out  1  combinational.

Behaviour:
- Operands:
  - A = sel[0] ? Fwd1 : Data1.
  - B0 = sel[1] ? Fwd2 : Data2.
  - B = IMM ? Immediate_Value : (OPS ? 16'd1 : B0).
- ALU_OP encoding:
  - 0: A+B.
  - 1: A−B.
  - 2: A&B.
  - 3: A|B.
  - 4: A<<B[3:0].
  - 5: A>>B[3:0] (logical).
  - 6: ~A.
  - 7: pass B.
- ALU results are 16 bits.
- Carry flag:
  - ADD: CF = 17th bit of the sum.
  - SUB: CF = borrow (A<B).
  - Shifts: CF = last bit shifted out; shift count 0 leaves CF unchanged.
  - AND/OR/NOT/pass leave CF unchanged.
- Data result priority:
  1. IOR: INPUT_PORT.
  2. SP with Stack_PC: PC.
  3. SP with Stack_Flags: {29'b0, Flags}.
  4. ALU=1: ALU result.
  5. Otherwise: A (MOV, store data, IOW).
- All 16-bit Data results are zero-extended to 32 bits.
- Stack (SP=1):
  - Step = 2 if Stack_PC, else 1.
  - Push (SPOP=0): Address = SP−step+1, Stack_Pointer_Out = SP−step.
  - Pop (SPOP=1): Address = SP+1, Stack_Pointer_Out = SP+step.
  - SP=0: Stack_Pointer_Out = Stack_Pointer.
  - SP arithmetic wraps modulo 2^32.
- Non-stack Address = {16'b0, B}.
- Flags:
  - Alu_flags = {result[15], CF, result==0}.
  - FD=00: keep Flags.
  - FD=01: Flags_From_Memory.
  - FD=10: Alu_flags if ALU=1, else Flags.
  - FD=11: 3'b000.
- Branch:
  - cond by FGS: 00 ZF, 01 NF, 10 CF, 11 always 1; evaluated on the incoming Flags.
  - Taken_Jump = JMP & cond.
  - When a conditional branch (FGS≠11) is taken, the tested flag is cleared in Final_Flags; this overrides FD.
  - To_PC_Selector = Taken_Jump & ~JWSP. The target is A, presented combinationally by the PC mux.
- Register:
  - All "_Out", Data, Address and Final_Flags load on every rising clk (no stall).
  - Latency is 1 cycle.
  - rst asynchronously clears all registered outputs to 0.
- Combinational outputs track the inputs during reset.

Optional Feature:
- Macro EX_SHIFT_EN.
- Defined: ALU_OP 4/5 shift as specified.
- Undefined: ALU_OP 4/5 produce result 0 and leave all three flags equal to Flags, regardless of FD.

Test Plan:
- MOV:
  - Stimulus: ALU=0, WB=1, WB_Address=7, FD=10, Data1=10, Data2=127, sel=00.
  - Response: after edge, Data=10, WB_Out=1, WB_Address_Out=7, Final_Flags=000.
- ADD:
  - Stimulus: ALU=1, ALU_OP=0, Data1=7, Data2=8, FD=10.
  - Response: Data=15, flags=000.
  - Same with Data1=16'hFFFF, Data2=1: Data=0, flags=011.
- SUB:
  - Stimulus: ALU_OP=1, Data1=23, Data2=8.
  - Response: Data=15, flags=000.
  - Data1=8, Data2=23: Data=16'hFFF1, flags=110.
- AND:
  - Stimulus: ALU_OP=2, Data1=4'b0101, Data2=4'b1010.
  - Response: Data=0, ZF=1.
  - Forwarding sel=01 with Fwd1=55: the ALU uses A=55, giving Data=55&10=2.
- Stack/branch, with Stack_Pointer=10:
  - Push Stack_PC, PC=15: Address=9, Stack_Pointer_Out=8, Data=15.
  - Pop: Stack_Pointer_Out=12.
  - JMP, FGS=00, Flags=001: Taken_Jump=1, To_PC_Selector=1, Final ZF=0.
- Reset: rst asserted mid-stream clears Data, Address and Final_Flags to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ex_stage_unit.sv
// Execute stage of the 16-bit pipelined processor.
// Selects operands, runs ALU / I/O / stack / address / branch logic and
// registers the 76-bit EX/MEM payload. Branch outputs are combinational.
// Optional feature: define EX_SHIFT_EN to enable ALU_OP 4/5 shifts; when
// undefined those ops yield 0 and pass the incoming flags through untouched.
module ex_stage_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        IOR,
   input  logic        IOW,
   input  logic        OPS,
   input  logic        ALU,
   input  logic        MR,
   input  logic        MW,
   input  logic        WB,
   input  logic        JMP,
   input  logic        SP,
   input  logic        SPOP,
   input  logic        JWSP,
   input  logic        IMM,
   input  logic        Stack_PC,
   input  logic        Stack_Flags,
   input  logic [1:0]  FD,
   input  logic [1:0]  FGS,
   input  logic [2:0]  ALU_OP,
   input  logic [2:0]  WB_Address,
   input  logic [2:0]  SRC_Address,
   input  logic [15:0] Data1,
   input  logic [15:0] Data2,
   input  logic [15:0] Immediate_Value,
   input  logic [31:0] PC,
   input  logic [1:0]  Forwarding_Unit_Selectors,
   input  logic [15:0] Data_From_Forwarding_Unit1,
   input  logic [15:0] Data_From_Forwarding_Unit2,
   input  logic [2:0]  Flags,
   input  logic [2:0]  Flags_From_Memory,
   input  logic [15:0] INPUT_PORT,
   input  logic [31:0] Stack_Pointer,
   output logic        MR_Out,
   output logic        MW_Out,
   output logic        WB_Out,
   output logic        JWSP_Out,
   output logic        Stack_PC_Out,
   output logic        Stack_Flags_Out,
   output logic [2:0]  WB_Address_Out,
   output logic [31:0] Data,
   output logic [31:0] Address,
   output logic [2:0]  Final_Flags,
   output logic [31:0] Stack_Pointer_Out,
   output logic        Taken_Jump,
   output logic        To_PC_Selector
);

   logic [15:0] w_a, w_b0, w_b, w_alu_res;
   logic        w_alu_cf, w_shift_off, w_cond;
   logic [16:0] w_sum;
   logic [31:0] w_shl, w_shr, w_step, w_data, w_addr;
   logic [2:0]  w_alu_flags, w_flags;
   // IOW and SRC_Address are consumed by later stages / hazard logic only.
   logic        w_unused;

   assign w_unused = IOW ^ (^SRC_Address);

   assign w_a   = Forwarding_Unit_Selectors[0] ? Data_From_Forwarding_Unit1 : Data1;
   assign w_b0  = Forwarding_Unit_Selectors[1] ? Data_From_Forwarding_Unit2 : Data2;
   assign w_b   = IMM ? Immediate_Value : (OPS ? 16'd1 : w_b0);
   assign w_sum = {1'b0, w_a} + {1'b0, w_b};
   // Widened shifts so the last bit shifted out lands at a fixed position.
   assign w_shl = {16'b0, w_a} << w_b[3:0];
   assign w_shr = {w_a, 16'b0} >> w_b[3:0];

   // ALU result and carry; carry defaults to the incoming CF.
   always_comb begin
      w_alu_res   = '0;
      w_alu_cf    = Flags[1];
      w_shift_off = 1'b0;
      case (ALU_OP)
         3'd0: begin
            w_alu_res = w_sum[15:0];
            w_alu_cf  = w_sum[16];
         end
         3'd1: begin
            w_alu_res = w_a - w_b;
            w_alu_cf  = (w_a < w_b);
         end
         3'd2: w_alu_res = w_a & w_b;
         3'd3: w_alu_res = w_a | w_b;
`ifdef EX_SHIFT_EN
         3'd4: begin
            w_alu_res = w_shl[15:0];
            if (w_b[3:0] != 4'd0) w_alu_cf = w_shl[16];
         end
         3'd5: begin
            w_alu_res = w_shr[31:16];
            if (w_b[3:0] != 4'd0) w_alu_cf = w_shr[15];
         end
`else
         3'd4, 3'd5: w_shift_off = 1'b1;
`endif
         3'd6: w_alu_res = ~w_a;
         default: w_alu_res = w_b;
      endcase
   end

   assign w_alu_flags = {w_alu_res[15], w_alu_cf, (w_alu_res == 16'd0)};

   // Branch condition on incoming flags {NF,CF,ZF}.
   always_comb begin
      w_cond = 1'b1;
      case (FGS)
         2'd0:    w_cond = Flags[0];
         2'd1:    w_cond = Flags[2];
         2'd2:    w_cond = Flags[1];
         default: w_cond = 1'b1;
      endcase
   end

   assign Taken_Jump     = JMP & w_cond;
   assign To_PC_Selector = Taken_Jump & ~JWSP;

   // Flag destination select, then disabled-shift passthrough, then branch clear.
   always_comb begin
      w_flags = Flags;
      case (FD)
         2'd0:    w_flags = Flags;
         2'd1:    w_flags = Flags_From_Memory;
         2'd2:    w_flags = ALU ? w_alu_flags : Flags;
         default: w_flags = 3'b000;
      endcase
      if (ALU && w_shift_off) w_flags = Flags;
      if (Taken_Jump && FGS != 2'd3) begin
         case (FGS)
            2'd0:    w_flags[0] = 1'b0;
            2'd1:    w_flags[2] = 1'b0;
            default: w_flags[1] = 1'b0;
         endcase
      end
   end

   // Data result priority mux.
   always_comb begin
      w_data = {16'b0, w_a};
      if (IOR)                      w_data = {16'b0, INPUT_PORT};
      else if (SP && Stack_PC)      w_data = PC;
      else if (SP && Stack_Flags)   w_data = {29'b0, Flags};
      else if (ALU)                 w_data = {16'b0, w_alu_res};
   end

   assign w_step = Stack_PC ? 32'd2 : 32'd1;

   // Stack pointer update and memory address.
   always_comb begin
      w_addr            = {16'b0, w_b};
      Stack_Pointer_Out = Stack_Pointer;
      if (SP) begin
         if (!SPOP) begin
            w_addr            = Stack_Pointer - w_step + 32'd1;
            Stack_Pointer_Out = Stack_Pointer - w_step;
         end else begin
            w_addr            = Stack_Pointer + 32'd1;
            Stack_Pointer_Out = Stack_Pointer + w_step;
         end
      end
   end

   // EX/MEM pipeline register, loads every cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         MR_Out          <= 1'b0;
         MW_Out          <= 1'b0;
         WB_Out          <= 1'b0;
         JWSP_Out        <= 1'b0;
         Stack_PC_Out    <= 1'b0;
         Stack_Flags_Out <= 1'b0;
         WB_Address_Out  <= 3'b0;
         Data            <= 32'b0;
         Address         <= 32'b0;
         Final_Flags     <= 3'b0;
      end else begin
         MR_Out          <= MR;
         MW_Out          <= MW;
         WB_Out          <= WB;
         JWSP_Out        <= JWSP;
         Stack_PC_Out    <= Stack_PC;
         Stack_Flags_Out <= Stack_Flags;
         WB_Address_Out  <= WB_Address;
         Data            <= w_data;
         Address         <= w_addr;
         Final_Flags     <= w_flags;
      end
   end

endmodule

// File: tb/tb_ex_stage_unit.sv
// Scoreboard bench for ex_stage_unit: stimulus pushes expected EX/MEM payloads,
// a monitor pops and compares one cycle later.
module tb_ex_stage_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic IOR, IOW, OPS, ALU, MR, MW, WB, JMP, SP, SPOP, JWSP, IMM, Stack_PC, Stack_Flags;
   logic [1:0]  FD, FGS, Forwarding_Unit_Selectors;
   logic [2:0]  ALU_OP, WB_Address, SRC_Address, Flags, Flags_From_Memory;
   logic [15:0] Data1, Data2, Immediate_Value, Data_From_Forwarding_Unit1;
   logic [15:0] Data_From_Forwarding_Unit2, INPUT_PORT;
   logic [31:0] PC, Stack_Pointer;
   logic MR_Out, MW_Out, WB_Out, JWSP_Out, Stack_PC_Out, Stack_Flags_Out;
   logic [2:0]  WB_Address_Out, Final_Flags;
   logic [31:0] Data, Address, Stack_Pointer_Out;
   logic Taken_Jump, To_PC_Selector;

   always #5 clk = ~clk;

   ex_stage_unit dut (
      .clk(clk), .rst(rst), .IOR(IOR), .IOW(IOW), .OPS(OPS), .ALU(ALU), .MR(MR), .MW(MW),
      .WB(WB), .JMP(JMP), .SP(SP), .SPOP(SPOP), .JWSP(JWSP), .IMM(IMM), .Stack_PC(Stack_PC),
      .Stack_Flags(Stack_Flags), .FD(FD), .FGS(FGS), .ALU_OP(ALU_OP), .WB_Address(WB_Address),
      .SRC_Address(SRC_Address), .Data1(Data1), .Data2(Data2),
      .Immediate_Value(Immediate_Value), .PC(PC),
      .Forwarding_Unit_Selectors(Forwarding_Unit_Selectors),
      .Data_From_Forwarding_Unit1(Data_From_Forwarding_Unit1),
      .Data_From_Forwarding_Unit2(Data_From_Forwarding_Unit2), .Flags(Flags),
      .Flags_From_Memory(Flags_From_Memory), .INPUT_PORT(INPUT_PORT),
      .Stack_Pointer(Stack_Pointer), .MR_Out(MR_Out), .MW_Out(MW_Out), .WB_Out(WB_Out),
      .JWSP_Out(JWSP_Out), .Stack_PC_Out(Stack_PC_Out), .Stack_Flags_Out(Stack_Flags_Out),
      .WB_Address_Out(WB_Address_Out), .Data(Data), .Address(Address),
      .Final_Flags(Final_Flags), .Stack_Pointer_Out(Stack_Pointer_Out),
      .Taken_Jump(Taken_Jump), .To_PC_Selector(To_PC_Selector)
   );

   typedef struct {
      logic ior, iow, ops, alu, mr, mw, wb, jmp, sp, spop, jwsp, imm, spc, sfl;
      logic [1:0]  fd, fgs, sel;
      logic [2:0]  op, wba, srca, flags, fmem;
      logic [15:0] d1, d2, immv, f1, f2, inp;
      logic [31:0] pc, stk;
   } stim_t;

   typedef struct {
      logic [31:0] data, addr;
      logic [2:0]  flags;
      logic [8:0]  ctl;
   } exp_t;

   exp_t q[$];
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic stim_t zero_stim();
      stim_t s;
      {s.ior, s.iow, s.ops, s.alu, s.mr, s.mw, s.wb, s.jmp, s.sp, s.spop, s.jwsp} = '0;
      {s.imm, s.spc, s.sfl} = '0;
      s.fd = 0; s.fgs = 0; s.sel = 0; s.op = 0; s.wba = 0; s.srca = 0;
      s.flags = 0; s.fmem = 0; s.d1 = 0; s.d2 = 0; s.immv = 0; s.f1 = 0; s.f2 = 0;
      s.inp = 0; s.pc = 0; s.stk = 0;
      return s;
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      logic [31:0] r;
      r = $urandom;
      {s.ior, s.iow, s.ops, s.alu, s.mr, s.mw, s.wb, s.jmp, s.sp, s.spop, s.jwsp} = r[10:0];
      {s.imm, s.spc, s.sfl} = r[13:11];
      s.fd = r[15:14]; s.fgs = r[17:16]; s.sel = r[19:18]; s.op = r[22:20];
      s.wba = r[25:23]; s.srca = r[28:26]; s.flags = 3'($urandom); s.fmem = 3'($urandom);
      s.d1 = 16'($urandom); s.d2 = 16'($urandom); s.immv = 16'($urandom);
      s.f1 = 16'($urandom); s.f2 = 16'($urandom); s.inp = 16'($urandom);
      s.pc = $urandom;
      s.stk = r[29] ? $urandom_range(0, 3) : $urandom;   // exercise wrap near 0
      // Small operands often, so shift counts and borrows hit edges.
      if (r[30]) begin s.d1 = 16'($urandom_range(0, 20)); s.d2 = 16'($urandom_range(0, 20)); end
      return s;
   endfunction

   // Reference model from the behavioural rules, plain arithmetic.
   task automatic model(input stim_t s, output exp_t e, output logic [31:0] spo,
                        output logic tj, output logic tpc);
      int unsigned a, b, sum, n, step;
      logic [15:0] res;
      logic cf, noshift, cond;
      logic [2:0] fl;
      a = s.sel[0] ? s.f1 : s.d1;
      b = s.imm ? s.immv : (s.ops ? 1 : (s.sel[1] ? s.f2 : s.d2));
      cf = s.flags[1]; noshift = 0; res = 0;
      n = b % 16;
      case (s.op)
         0: begin sum = a + b; res = 16'(sum); cf = (sum > 65535); end
         1: begin res = 16'(a - b); cf = (a < b); end
         2: res = 16'(a & b);
         3: res = 16'(a | b);
         4: begin
`ifdef EX_SHIFT_EN
            res = 16'((a * (1 << n)) % 65536);
            if (n != 0) cf = ((a >> (16 - n)) % 2) == 1;
`else
            noshift = 1;
`endif
         end
         5: begin
`ifdef EX_SHIFT_EN
            res = 16'(a / (1 << n));
            if (n != 0) cf = ((a >> (n - 1)) % 2) == 1;
`else
            noshift = 1;
`endif
         end
         6: res = 16'(65535 - a);
         default: res = 16'(b);
      endcase
      if (s.ior)               e.data = {16'b0, s.inp};
      else if (s.sp && s.spc)  e.data = s.pc;
      else if (s.sp && s.sfl)  e.data = {29'b0, s.flags};
      else if (s.alu)          e.data = {16'b0, res};
      else                     e.data = a;
      step = s.spc ? 2 : 1;
      if (!s.sp) begin e.addr = b; spo = s.stk; end
      else if (!s.spop) begin e.addr = s.stk - step + 1; spo = s.stk - step; end
      else begin e.addr = s.stk + 1; spo = s.stk + step; end
      case (s.fd)
         0: fl = s.flags;
         1: fl = s.fmem;
         2: fl = s.alu ? {res[15], cf, res == 16'd0} : s.flags;
         default: fl = 3'b000;
      endcase
      if (s.alu && noshift) fl = s.flags;
      case (s.fgs)
         0: cond = s.flags[0];
         1: cond = s.flags[2];
         2: cond = s.flags[1];
         default: cond = 1;
      endcase
      tj = s.jmp && cond;
      if (tj && s.fgs == 0) fl[0] = 0;
      if (tj && s.fgs == 1) fl[2] = 0;
      if (tj && s.fgs == 2) fl[1] = 0;
      tpc = tj && !s.jwsp;
      e.flags = fl;
      e.ctl = {s.mr, s.mw, s.wb, s.jwsp, s.spc, s.sfl, s.wba};
   endtask

   task automatic drive(input stim_t s);
      IOR = s.ior; IOW = s.iow; OPS = s.ops; ALU = s.alu; MR = s.mr; MW = s.mw; WB = s.wb;
      JMP = s.jmp; SP = s.sp; SPOP = s.spop; JWSP = s.jwsp; IMM = s.imm; Stack_PC = s.spc;
      Stack_Flags = s.sfl; FD = s.fd; FGS = s.fgs; Forwarding_Unit_Selectors = s.sel;
      ALU_OP = s.op; WB_Address = s.wba; SRC_Address = s.srca; Flags = s.flags;
      Flags_From_Memory = s.fmem; Data1 = s.d1; Data2 = s.d2; Immediate_Value = s.immv;
      Data_From_Forwarding_Unit1 = s.f1; Data_From_Forwarding_Unit2 = s.f2;
      INPUT_PORT = s.inp; PC = s.pc; Stack_Pointer = s.stk;
   endtask

   // Issue one transaction: check combinational outputs, queue registered ones.
   task automatic apply(input stim_t s);
      exp_t e;
      logic [31:0] spo;
      logic tj, tpc;
      @(negedge clk);
      drive(s);
      #1;
      model(s, e, spo, tj, tpc);
      check("sp_out", Stack_Pointer_Out, spo);
      check("taken_jump", {31'b0, Taken_Jump}, {31'b0, tj});
      check("to_pc_sel", {31'b0, To_PC_Selector}, {31'b0, tpc});
      q.push_back(e);
   endtask

   // Monitor: payload is valid every cycle out of reset.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!rst && q.size() > 0) begin
            e = q.pop_front();
            check("data", Data, e.data);
            check("address", Address, e.addr);
            check("final_flags", {29'b0, Final_Flags}, {29'b0, e.flags});
            check("ctl", {23'b0, MR_Out, MW_Out, WB_Out, JWSP_Out, Stack_PC_Out,
                          Stack_Flags_Out, WB_Address_Out}, {23'b0, e.ctl});
         end
      end
   end

   task automatic drain();
      int budget = 10;
      while (q.size() > 0 && budget > 0) begin
         @(posedge clk);
         #2;
         budget--;
      end
      check("drain_empty", q.size(), 0);
   endtask

   initial begin
      stim_t s;
      drive(zero_stim());
      #2;
      check("rst_data", Data, 0);
      check("rst_addr", Address, 0);
      check("rst_flags", {29'b0, Final_Flags}, 0);
      @(negedge clk);
      rst = 1'b0;

      // MOV
      s = zero_stim(); s.wb = 1; s.wba = 7; s.fd = 2; s.d1 = 10; s.d2 = 127; apply(s);
      // ADD
      s = zero_stim(); s.alu = 1; s.op = 0; s.d1 = 7; s.d2 = 8; s.fd = 2; apply(s);
      s.d1 = 16'hFFFF; s.d2 = 1; apply(s);
      // SUB
      s.op = 1; s.d1 = 23; s.d2 = 8; apply(s);
      s.d1 = 8; s.d2 = 23; apply(s);
      // AND, then with forwarded A
      s.op = 2; s.d1 = 5; s.d2 = 10; apply(s);
      s.sel = 2'b01; s.f1 = 55; apply(s);
      // Push PC, pop, conditional jump on ZF
      s = zero_stim(); s.sp = 1; s.spc = 1; s.pc = 15; s.stk = 10; apply(s);
      s = zero_stim(); s.sp = 1; s.spop = 1; s.spc = 1; s.stk = 10; apply(s);
      s = zero_stim(); s.jmp = 1; s.fgs = 0; s.flags = 3'b001; s.d1 = 16'h40; apply(s);
      // Stack pointer wrap at zero
      s = zero_stim(); s.sp = 1; s.spc = 1; s.stk = 0; apply(s);
      s.spop = 1; s.stk = 32'hFFFF_FFFF; apply(s);

      for (int i = 0; i < 400; i++) apply(rand_stim());
      drain();

      // Load a nonzero payload, then reset asynchronously between edges.
      s = zero_stim(); s.d1 = 16'h1234; s.d2 = 16'h0055; s.fd = 1; s.fmem = 3'b111;
      s.wb = 1; s.wba = 5; apply(s);
      drain();
      rst = 1'b1;
      #1;
      check("async_rst_data", Data, 0);
      check("async_rst_addr", Address, 0);
      check("async_rst_flags", {29'b0, Final_Flags}, 0);
      check("async_rst_wb", {31'b0, WB_Out}, 0);
      @(negedge clk);
      rst = 1'b0;
      s = zero_stim(); s.ior = 1; s.inp = 16'hBEEF; s.d2 = 3; apply(s);
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
